bm_result_collector: RTL
========================

BM_RESULT_COLLECTOR -- requirements
Module: bm_result_collector

Interface
REQ-001 Parameter DATA_W, default 16: result width, matching the upstream out0 bus.
REQ-002 Parameter TAG_W, default 8: tag width, matching the upstream counter bus.
REQ-003 Parameter DEPTH, default 4: FIFO entries; power of two, minimum 2.
REQ-004 clock  input  1: single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1: reset, asynchronous and active-low.
REQ-006 in_data  input  DATA_W: result word from the upstream functional stage.
REQ-007 in_tag  input  TAG_W: upstream counter value accompanying in_data.
REQ-008 in_flag  input  1: upstream out1 flag, stored with the entry.
REQ-009 in_valid  input  1: the in_* bus carries a record this cycle.
REQ-010 in_ready  output  1: FIFO not full.
REQ-011 out_data  output  DATA_W: head-entry data.
REQ-012 out_tag  output  TAG_W: head-entry tag.
REQ-013 out_flag  output  1: head-entry flag.
REQ-014 out_valid  output  1: FIFO not empty.
REQ-015 out_ready  input  1: consumer accepts the head entry.
REQ-016 level  output  log2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-017 overflow  output  1: sticky; a record was dropped.
REQ-018 seq_err  output  1: sticky; tag discontinuity detected.
REQ-019 checksum  output  DATA_W: running sum of accepted data.

Function
REQ-020 Push = in_valid & in_ready; pop = out_valid & out_ready; both are evaluated in the same cycle.
REQ-021 in_ready = (level != DEPTH), decided combinationally from registered level; a pop in the same cycle does not free a slot for a push.
REQ-022 First-word-fall-through: a record pushed at edge N appears on out_* from edge N (available in cycle N+1); out_* are undefined-free and hold 0 when empty.
REQ-023 Simultaneous push and pop with 0 < level < DEPTH leave level unchanged; the order of entries is preserved.
REQ-024 in_valid asserted while level == DEPTH drops the record, sets overflow, and leaves FIFO contents, level, checksum and tag tracking unchanged.
REQ-025 A pop when empty cannot occur, because out_valid is 0; out_ready is ignored when empty.
REQ-026 Read and write pointers wrap modulo DEPTH; level increments or decrements by at most 1 per cycle.
REQ-027 Tag check: the first push after reset loads expected = in_tag + 1 with no check; each later push compares in_tag with expected, sets seq_err on mismatch, then loads expected = in_tag + 1.
REQ-028 All expected-tag arithmetic is modulo 2^TAG_W, so tag 255 followed by tag 0 is in sequence.
REQ-029 overflow and seq_err are sticky and clear only on reset.

Reset
REQ-030 When reset_n is low, the block asynchronously forces: level=0, pointers=0, out_valid=0, in_ready=1, out_data/out_tag/out_flag=0, overflow=0, seq_err=0, checksum=0, and the first-push marker set.
REQ-031 A reset asserted mid-operation discards all stored entries; the first edge after release may accept a push.

Configuration
REQ-032 Macro RESULT_CHECKSUM_EN defined: on each push, checksum <= checksum + in_data modulo 2^DATA_W; dropped records are not summed.
REQ-033 Macro RESULT_CHECKSUM_EN undefined: the checksum port remains present and is tied to 0, and no adder is synthesised.

Verification
REQ-034 Push data 0x0011, 0x0022, 0x0033 with tags 0, 1, 2 while out_ready=0 -> level=3; out_data=0x0011; seq_err=0.
REQ-035 Hold out_ready=1 on the queue from REQ-034 -> out_data reads 0x0011, 0x0022, 0x0033 on consecutive cycles; then out_valid=0 and level=0.
REQ-036 Push 5 records with DEPTH=4 and out_ready=0 -> in_ready=0 after the 4th push; the 5th record is dropped; overflow=1; level=4.
REQ-037 Push tags 254, 255, 0, then 2 -> seq_err stays 0 through tag 0 and sets on tag 2.
REQ-038 With RESULT_CHECKSUM_EN defined, push 0xFFFF then 0x0003 -> checksum=0x0002; with the macro undefined, checksum=0.
REQ-039 Drive reset_n low asynchronously with level=2 -> all outputs reach reset values before the next clock edge; after release, a push with tag 9 sets no seq_err.

Source files
------------

// File: rtl/bm_result_collector.sv
// bm_result_collector: first-word-fall-through result FIFO with tag sequence
// checking, sticky overflow/sequence-error flags and an optional running
// checksum of accepted data.
// Optional feature macro: RESULT_CHECKSUM_EN (checksum adder enabled when defined).
module bm_result_collector #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic                         in_flag,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         out_flag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow,
    output logic                         seq_err,
    output logic [DATA_W-1:0]            checksum
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [TAG_W-1:0]  mem_tag  [DEPTH];
    logic              mem_flag [DEPTH];

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [TAG_W-1:0]  exp_tag;
    logic              first_push;
    logic              push;
    logic              pop;

    // Handshake decode; readiness depends only on registered occupancy.
    always_comb begin
        in_ready  = (level != LW'(DEPTH));
        out_valid = (level != LW'(0));
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Head entry falls through to the outputs; zero while empty.
    always_comb begin
        out_data = '0;
        out_tag  = '0;
        out_flag = 1'b0;
        if (out_valid) begin
            out_data = mem_data[rd_ptr];
            out_tag  = mem_tag[rd_ptr];
            out_flag = mem_flag[rd_ptr];
        end
    end

    // Storage array; contents need no reset because reads are gated by level.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_tag[wr_ptr]  <= in_tag;
            mem_flag[wr_ptr] <= in_flag;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow on any record offered while full.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end
    end

    // Tag continuity: first accepted record only seeds the expected tag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            first_push <= 1'b1;
            exp_tag    <= '0;
            seq_err    <= 1'b0;
        end else if (push) begin
            first_push <= 1'b0;
            exp_tag    <= in_tag + TAG_W'(1);
            if (!first_push && (in_tag != exp_tag)) begin
                seq_err <= 1'b1;
            end
        end
    end

`ifdef RESULT_CHECKSUM_EN
    // Running modulo-2^DATA_W sum of accepted data only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (push) begin
            checksum <= checksum + in_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule
